// File: rtl/sub100_seq.sv
// Multi-cycle WIDTH-bit subtractor computing a - b - bin, CHUNK bits per clock, with valid/ready handshakes.
// Define SUB_OVERFLOW_EN to add the signed-overflow output ovf.
module sub100_seq #(
    parameter int unsigned WIDTH = 100,
    parameter int unsigned CHUNK = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    if (WIDTH % CHUNK != 0) begin : g_chunk_check
        $error("sub100_seq: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r, diff_r;
    logic             borrow;
    logic [CNT_W-1:0] cnt;
    logic             load, step, last;
    logic [CHUNK-1:0] a_k, b_k;
    logic [CHUNK:0]   sub_k;

    assign last = (cnt == CNT_W'(N - 1));
    assign a_k  = a_r[cnt*CHUNK +: CHUNK];
    assign b_k  = b_r[cnt*CHUNK +: CHUNK];

    // One extra bit on the left collects the borrow out of this chunk.
    always_comb begin
        sub_k = {1'b0, a_k} - {1'b0, b_k} - {{CHUNK{1'b0}}, borrow};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load     = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            diff_r <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
        end else if (load) begin
            a_r    <= a;
            b_r    <= b;
            borrow <= bin;
            cnt    <= '0;
        end else if (step) begin
            diff_r[cnt*CHUNK +: CHUNK] <= sub_k[CHUNK-1:0];
            borrow                     <= sub_k[CHUNK];
            cnt                        <= cnt + 1'b1;
        end
    end

    assign diff = diff_r;
    assign bout = (state == DONE) && borrow;

`ifdef SUB_OVERFLOW_EN
    assign ovf = (state == DONE) && (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_r[WIDTH-1] != a_r[WIDTH-1]);
`endif

endmodule

// File: tb/tb_sub100_seq.sv
// Scoreboard bench for sub100_seq: driver pushes expected results, a negedge monitor pops and compares.
// Build with SUB_OVERFLOW_EN defined to also exercise the ovf output.
module tb_sub100_seq;

    localparam int unsigned W   = 100;
    localparam int unsigned C   = 10;
    localparam int unsigned LAT = W / C;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SUB_OVERFLOW_EN
    logic         ovf;
`endif

    sub100_seq #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout)
`ifdef SUB_OVERFLOW_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t exp_q[$];
    int   acc_q[$];
    logic prev_v     = 1'b0;
    logic rand_ready = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Reference: plain wide arithmetic with one extra bit to expose the borrow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        logic [W:0] full;
        exp_t       e;
        full = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
        e.d  = full[W-1:0];
        e.bo = full[W];
        e.ov = (x[W-1] != y[W-1]) && (e.d[W-1] != x[W-1]);
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_w();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[W-1:0];
    endfunction

    // Monitor: latency on the rising edge of out_valid, values on each handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (out_valid && !prev_v) begin
                if (acc_q.size() == 0) timeout_fail("unexpected out_valid");
                else chk("latency", 128'(cyc - acc_q.pop_front()), 128'(LAT));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    timeout_fail("result with empty scoreboard");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("diff", 128'(diff), 128'(e.d));
                    chk("bout", 128'(bout), 128'(e.bo));
`ifdef SUB_OVERFLOW_EN
                    chk("ovf", 128'(ovf), 128'(e.ov));
`endif
                end
            end
            prev_v = out_valid;
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        int t = 0;
        while (!in_ready && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) begin
            timeout_fail("in_ready wait");
            return;
        end
        a = x; b = y; bin = bi; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        exp_q.push_back(model(x, y, bi));
        acc_q.push_back(cyc);
    endtask

    task automatic wait_out_valid(input string name);
        int t = 0;
        @(negedge clk);
        while (!out_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) timeout_fail(name);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (exp_q.size() != 0) timeout_fail("drain");
    endtask

    initial begin
        logic [W-1:0] one_w, all1, p50, p99;
        exp_t         e;
        one_w = {{(W-1){1'b0}}, 1'b1};
        all1  = '1;
        p50   = one_w << 50;
        p99   = one_w << 99;

        // 1: reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst in_ready", 128'(in_ready), 128'(1));
        chk("rst out_valid", 128'(out_valid), 128'(0));
        chk("rst diff", 128'(diff), 128'(0));
        chk("rst bout", 128'(bout), 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 2: basic op, then return to IDLE the cycle after the handshake
        do_op(W'(1000), one_w, 1'b0);
        wait_out_valid("op 1000-1");
        @(posedge clk); #1;
        chk("post-hs out_valid", 128'(out_valid), 128'(0));
        chk("post-hs in_ready", 128'(in_ready), 128'(1));
`ifdef SUB_OVERFLOW_EN
        chk("idle ovf", 128'(ovf), 128'(0));
`endif

        // 3/4: wrap-around and cross-chunk borrow
        do_op('0, one_w, 1'b0);
        do_op(W'(5), W'(5), 1'b1);
        do_op(W'(9), W'(9), 1'b0);
        do_op(p50, one_w, 1'b0);
        do_op('0, p99, 1'b0);
        do_op(all1, all1, 1'b1);
        do_op(all1, '0, 1'b1);
        wait_drain();

        // 5: in_valid ignored in RUN; back-pressure holds DONE
        e = model(rnd_w(), '0, 1'b0);
        a = rnd_w();
        b = rnd_w();
        e = model(a, b, 1'b1);
        do_op(a, b, 1'b1);
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("run in_ready", 128'(in_ready), 128'(0));
        a = rnd_w(); b = rnd_w(); in_valid = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        in_valid = 1'b0;
        wait_out_valid("backpressure op");
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("hold out_valid", 128'(out_valid), 128'(1));
            chk("hold in_ready", 128'(in_ready), 128'(0));
            chk("hold diff", 128'(diff), 128'(e.d));
            chk("hold bout", 128'(bout), 128'(e.bo));
        end
        out_ready = 1'b1;
        wait_drain();
        repeat (3) begin @(posedge clk); #1; end
        chk("no stray result", 128'(out_valid), 128'(0));

        // 6: reset in RUN aborts immediately
        do_op(rnd_w(), rnd_w(), 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        chk("abort in_ready", 128'(in_ready), 128'(1));
        chk("abort out_valid", 128'(out_valid), 128'(0));
        chk("abort diff", 128'(diff), 128'(0));
        chk("abort bout", 128'(bout), 128'(0));
`ifdef SUB_OVERFLOW_EN
        chk("abort ovf", 128'(ovf), 128'(0));
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op(W'(7), W'(3), 1'b0);
        wait_drain();

        // Random operands with random back-pressure
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] x, y;
            x = rnd_w();
            case ($urandom_range(0, 4))
                0: y = x;
                1: y = x + one_w;
                2: y = one_w << $urandom_range(0, W - 1);
                default: y = rnd_w();
            endcase
            do_op(x, y, 1'($urandom_range(0, 1)));
        end
        wait_drain();
        rand_ready = 1'b0;
        #2;
        out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        chk("final idle", 128'(in_ready), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
